// File: rtl/stage_wb.sv
// -----------------------------------------------------------------------------
// stage_wb : write-back stage of the multithreaded pipeline.
//
// Consumes the TL->WB pipeline register and retires instructions in the same
// cycle they arrive: register-file write, fetch redirect (jump, taken branch,
// iret, exception entry, store replay) and TLB writes. Per-thread exception
// state (rm0 = faulting pc, rm1 = faulting address, rm2 = cause) and the
// supervisor mode bit are registered here. Committed stores go into a FIFO
// store buffer that drains into the D-cache STORE interface, one per cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tl_*                     TL->WB pipeline register (thread, valid, TLB
//                            misses, dst, pc, r2, data, paddr, compare result,
//                            multiplier result, decode flags, tlbwrite kind)
//   rf_wen/thread/dst/data   register-file write port
//   redir_en/thread/pc       fetch redirect
//   replay                   store rejected (buffer full); thread refetches pc
//   itlb/dtlb_write_en,
//   write_vpn, write_ppn     TLB write port (supervisor mode only)
//   store_en/isbyte/addr/data, store_ready
//                            D-cache STORE interface (head of store buffer)
//   sb_empty                 store buffer holds no entries
//   mode                     per-thread supervisor bit (1 = supervisor)
// -----------------------------------------------------------------------------
module stage_wb #(
    parameter int          SB_DEPTH   = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
    parameter int          N_THREADS  = 4,
    parameter int          TID_W      = 2,
    parameter int          REG_W      = 5,
    parameter int          WORD_W     = 32,
    parameter int          PADDR_W    = 20,
    parameter int          PAGE_W     = 12
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [TID_W-1:0]            tl_thread,
    input  logic                        tl_isvalid,
    input  logic                        tl_itlb_miss,
    input  logic                        tl_dtlb_miss,
    input  logic [REG_W-1:0]            tl_dst,
    input  logic [WORD_W-1:0]           tl_pc,
    input  logic [WORD_W-1:0]           tl_r2,
    input  logic [WORD_W-1:0]           tl_data,
    input  logic [PADDR_W-1:0]          tl_paddr,
    input  logic                        tl_isequal,
    input  logic [WORD_W-1:0]           tl_mul,
    input  logic                        tl_flag_mul,
    input  logic                        tl_flag_reg,
    input  logic                        tl_flag_jump,
    input  logic                        tl_flag_branch,
    input  logic                        tl_flag_iret,
    input  logic                        tl_flag_store,
    input  logic                        tl_flag_isbyte,
    input  logic [1:0]                  tl_flag_tlbwrite,

    output logic                        rf_wen,
    output logic [TID_W-1:0]            rf_thread,
    output logic [REG_W-1:0]            rf_dst,
    output logic [WORD_W-1:0]           rf_data,

    output logic                        redir_en,
    output logic [TID_W-1:0]            redir_thread,
    output logic [WORD_W-1:0]           redir_pc,
    output logic                        replay,

    output logic                        itlb_write_en,
    output logic                        dtlb_write_en,
    output logic [WORD_W-PAGE_W-1:0]    write_vpn,
    output logic [PADDR_W-PAGE_W-1:0]   write_ppn,

    output logic                        store_en,
    output logic                        store_isbyte,
    output logic [PADDR_W-1:0]          store_addr,
    output logic [WORD_W-1:0]           store_data,
    input  logic                        store_ready,

    output logic                        sb_empty,
    output logic [N_THREADS-1:0]        mode
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] SB_FULL = CNT_W'(SB_DEPTH);

    localparam logic [1:0] TLBW_NONE = 2'd0;
    localparam logic [1:0] TLBW_ITLB = 2'd1;
    localparam logic [1:0] TLBW_DTLB = 2'd2;

    localparam logic [WORD_W-1:0] CAUSE_ITLB = WORD_W'(1);
    localparam logic [WORD_W-1:0] CAUSE_DTLB = WORD_W'(2);

    // Per-thread exception state.
    logic [WORD_W-1:0] rm0 [N_THREADS];
    logic [WORD_W-1:0] rm1 [N_THREADS];
    logic [WORD_W-1:0] rm2 [N_THREADS];

    // Store buffer storage and bookkeeping.
    logic               sb_isbyte [SB_DEPTH];
    logic [PADDR_W-1:0] sb_addr   [SB_DEPTH];
    logic [WORD_W-1:0]  sb_data   [SB_DEPTH];
    logic [PTR_W-1:0]   sb_wrptr;
    logic [PTR_W-1:0]   sb_rdptr;
    logic [CNT_W-1:0]   sb_count;

    logic ret;
    logic exc;
    logic pop;
    logic accept;
    logic push;
    logic commit;
    logic tlb_ok;

    // ------------------------------------------------------------------
    // Retire / exception decode
    // ------------------------------------------------------------------
    assign ret = tl_isvalid & ~tl_itlb_miss & ~tl_dtlb_miss;
    assign exc = tl_isvalid & (tl_itlb_miss | tl_dtlb_miss);

    // A full buffer can still take a store when the head leaves this cycle.
    assign pop    = store_en & store_ready;
    assign accept = (sb_count < SB_FULL) | pop;
    assign replay = ret & tl_flag_store & ~accept;
    assign push   = ret & tl_flag_store & accept;

    // A replayed store does not retire, so none of its side effects happen.
    assign commit = ret & ~replay;

    assign rf_wen    = commit & tl_flag_reg;
    assign rf_thread = tl_thread;
    assign rf_dst    = tl_dst;
    assign rf_data   = tl_flag_mul ? tl_mul : tl_data;

    // Redirect priority: exception entry, then store replay, then control flow.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the if/else chain leaves it holding a value (latch).
        redir_en     = 1'b0;
        redir_thread = tl_thread;
        redir_pc     = tl_data;
        if (exc) begin
            redir_en = 1'b1;
            redir_pc = EXC_VECTOR;
        end else if (replay) begin
            redir_en = 1'b1;
            redir_pc = tl_pc;
        end else if (ret && tl_flag_iret) begin
            redir_en = 1'b1;
            redir_pc = rm0[tl_thread];
        end else if (ret && (tl_flag_jump || (tl_flag_branch && tl_isequal))) begin
            redir_en = 1'b1;
            redir_pc = tl_data;
        end
    end

    // TLB writes are privileged; in user mode the instruction retires as a no-op.
    assign tlb_ok        = commit & mode[tl_thread];
    assign itlb_write_en = tlb_ok & (tl_flag_tlbwrite == TLBW_ITLB);
    assign dtlb_write_en = tlb_ok & (tl_flag_tlbwrite == TLBW_DTLB);
    assign write_vpn     = tl_data[WORD_W-1:PAGE_W];
    assign write_ppn     = tl_r2[PADDR_W-PAGE_W-1:0];

    // ------------------------------------------------------------------
    // Per-thread exception state and supervisor mode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every flop samples its inputs as they were before the edge.
            mode <= '1;
            for (int t = 0; t < N_THREADS; t++) begin
                rm0[t] <= '0;
                rm1[t] <= '0;
                rm2[t] <= '0;
            end
        end else if (exc) begin
            rm0[tl_thread]  <= tl_pc;
            rm1[tl_thread]  <= tl_itlb_miss ? tl_pc : tl_data;
            rm2[tl_thread]  <= tl_itlb_miss ? CAUSE_ITLB : CAUSE_DTLB;
            mode[tl_thread] <= 1'b1;
        end else if (commit && tl_flag_iret) begin
            mode[tl_thread] <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Store buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_wrptr <= '0;
            sb_rdptr <= '0;
            sb_count <= '0;
        end else begin
            // Pointers are PTR_W wide and SB_DEPTH is a power of two, so the
            // increment wraps modulo SB_DEPTH on its own.
            if (push) sb_wrptr <= sb_wrptr + 1'b1;
            if (pop)  sb_rdptr <= sb_rdptr + 1'b1;
            case ({push, pop})
                2'b10:   sb_count <= sb_count + 1'b1;
                2'b01:   sb_count <= sb_count - 1'b1;
                default: sb_count <= sb_count;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; a cleared count makes every entry
    // invalid, so resetting the payload would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_isbyte[sb_wrptr] <= tl_flag_isbyte;
            sb_addr[sb_wrptr]   <= tl_paddr;
            sb_data[sb_wrptr]   <= tl_r2;
        end
    end

    assign store_en     = (sb_count != '0);
    assign sb_empty     = (sb_count == '0);
    assign store_isbyte = sb_isbyte[sb_rdptr];
    assign store_addr   = sb_addr[sb_rdptr];
    assign store_data   = sb_data[sb_rdptr];

    // Unused tlbwrite encoding kept explicit for readers of the decode.
    logic unused_tlbw_none;
    assign unused_tlbw_none = (tl_flag_tlbwrite == TLBW_NONE);

endmodule

// File: tb/tb_stage_wb.sv
module tb_stage_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  tl_thread;
    logic        tl_isvalid, tl_itlb_miss, tl_dtlb_miss;
    logic [4:0]  tl_dst;
    logic [31:0] tl_pc, tl_r2, tl_data, tl_mul;
    logic [19:0] tl_paddr;
    logic        tl_isequal;
    logic        tl_flag_mul, tl_flag_reg, tl_flag_jump, tl_flag_branch;
    logic        tl_flag_iret, tl_flag_store, tl_flag_isbyte;
    logic [1:0]  tl_flag_tlbwrite;
    logic        rf_wen;
    logic [1:0]  rf_thread;
    logic [4:0]  rf_dst;
    logic [31:0] rf_data;
    logic        redir_en;
    logic [1:0]  redir_thread;
    logic [31:0] redir_pc;
    logic        replay;
    logic        itlb_write_en, dtlb_write_en;
    logic [19:0] write_vpn;
    logic [7:0]  write_ppn;
    logic        store_en, store_isbyte;
    logic [19:0] store_addr;
    logic [31:0] store_data;
    logic        store_ready;
    logic        sb_empty;
    logic [3:0]  mode;

    stage_wb #(.SB_DEPTH(4), .EXC_VECTOR(32'h0000_2000)) dut (
        .clk(clk), .rst(rst),
        .tl_thread(tl_thread), .tl_isvalid(tl_isvalid),
        .tl_itlb_miss(tl_itlb_miss), .tl_dtlb_miss(tl_dtlb_miss),
        .tl_dst(tl_dst), .tl_pc(tl_pc), .tl_r2(tl_r2), .tl_data(tl_data),
        .tl_paddr(tl_paddr), .tl_isequal(tl_isequal), .tl_mul(tl_mul),
        .tl_flag_mul(tl_flag_mul), .tl_flag_reg(tl_flag_reg),
        .tl_flag_jump(tl_flag_jump), .tl_flag_branch(tl_flag_branch),
        .tl_flag_iret(tl_flag_iret), .tl_flag_store(tl_flag_store),
        .tl_flag_isbyte(tl_flag_isbyte), .tl_flag_tlbwrite(tl_flag_tlbwrite),
        .rf_wen(rf_wen), .rf_thread(rf_thread), .rf_dst(rf_dst), .rf_data(rf_data),
        .redir_en(redir_en), .redir_thread(redir_thread), .redir_pc(redir_pc),
        .replay(replay),
        .itlb_write_en(itlb_write_en), .dtlb_write_en(dtlb_write_en),
        .write_vpn(write_vpn), .write_ppn(write_ppn),
        .store_en(store_en), .store_isbyte(store_isbyte),
        .store_addr(store_addr), .store_data(store_data),
        .store_ready(store_ready),
        .sb_empty(sb_empty), .mode(mode)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int drained;

    typedef struct packed {
        logic        isbyte;
        logic [19:0] addr;
        logic [31:0] data;
    } st_t;

    st_t sb_q[$];

    task automatic set_idle();
        tl_thread = 2'd0; tl_isvalid = 1'b0; tl_itlb_miss = 1'b0; tl_dtlb_miss = 1'b0;
        tl_dst = 5'd0; tl_pc = 32'd0; tl_r2 = 32'd0; tl_data = 32'd0; tl_mul = 32'd0;
        tl_paddr = 20'd0; tl_isequal = 1'b0;
        tl_flag_mul = 1'b0; tl_flag_reg = 1'b0; tl_flag_jump = 1'b0; tl_flag_branch = 1'b0;
        tl_flag_iret = 1'b0; tl_flag_store = 1'b0; tl_flag_isbyte = 1'b0;
        tl_flag_tlbwrite = 2'd0;
    endtask

    // Drives a store on the TL register; returns the expected buffer entry.
    task automatic drive_store(input logic [31:0] pc, input logic [19:0] addr,
                               input logic isbyte, output st_t e);
        set_idle();
        tl_isvalid = 1'b1; tl_flag_store = 1'b1; tl_thread = 2'd0;
        tl_pc = pc; tl_paddr = addr; tl_r2 = $urandom; tl_flag_isbyte = isbyte;
        e = '{isbyte: isbyte, addr: addr, data: tl_r2};
    endtask

    // Samples the drain port against the scoreboard, then advances one cycle.
    task automatic step();
        st_t e;
        #1;
        if (store_en && store_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got store addr=%h, expected no store", store_addr);
            end else begin
                e = sb_q.pop_front();
                if ({store_isbyte, store_addr, store_data} !== e) begin
                    bad++;
                    $display("FAIL sb_order: got %h expected %h",
                             {store_isbyte, store_addr, store_data}, e);
                end
                drained++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; store_ready = 1'b0; set_idle();
        @(negedge clk); #1;
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rst_sb_empty: got %b expected 1", sb_empty); end
        total++; if (store_en !== 1'b0) begin bad++; $display("FAIL rst_store_en: got %b expected 0", store_en); end
        total++; if (mode !== 4'hF) begin bad++; $display("FAIL rst_mode: got %h expected f", mode); end
        total++; if (redir_en !== 1'b0 || rf_wen !== 1'b0) begin bad++; $display("FAIL rst_idle: got redir=%b wen=%b expected 0 0", redir_en, rf_wen); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        set_idle();
        tl_isvalid = 1'b1; tl_thread = 2'd1; tl_flag_reg = 1'b1; tl_dst = 5'd5;
        tl_data = 32'h1234; tl_mul = 32'hDEAD_BEEF;
        #1;
        total++; if (rf_wen !== 1'b1 || rf_dst !== 5'd5 || rf_thread !== 2'd1) begin bad++; $display("FAIL alu_ctl: got wen=%b dst=%0d thr=%0d expected 1 5 1", rf_wen, rf_dst, rf_thread); end
        total++; if (rf_data !== 32'h1234) begin bad++; $display("FAIL alu_data: got %h expected 00001234", rf_data); end
        total++; if (redir_en !== 1'b0) begin bad++; $display("FAIL alu_redir: got %b expected 0", redir_en); end
        tl_flag_mul = 1'b1;
        #1;
        total++; if (rf_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mul_data: got %h expected deadbeef", rf_data); end
        tl_isvalid = 1'b0;
        #1;
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL invalid_wen: got %b expected 0", rf_wen); end
        step();
    endtask

    task automatic test_branch();
        set_idle();
        tl_isvalid = 1'b1; tl_thread = 2'd3; tl_flag_branch = 1'b1; tl_isequal = 1'b1; tl_data = 32'h400;
        #1;
        total++; if (redir_en !== 1'b1 || redir_pc !== 32'h400 || redir_thread !== 2'd3) begin bad++; $display("FAIL br_taken: got en=%b pc=%h thr=%0d expected 1 00000400 3", redir_en, redir_pc, redir_thread); end
        tl_isequal = 1'b0;
        #1;
        total++; if (redir_en !== 1'b0) begin bad++; $display("FAIL br_not_taken: got %b expected 0", redir_en); end
        tl_flag_branch = 1'b0; tl_flag_jump = 1'b1; tl_data = 32'h0000_0A80;
        #1;
        total++; if (redir_en !== 1'b1 || redir_pc !== 32'h0A80) begin bad++; $display("FAIL jump: got en=%b pc=%h expected 1 00000a80", redir_en, redir_pc); end
        step();
    endtask

    task automatic test_exception();
        set_idle();
        tl_isvalid = 1'b1; tl_thread = 2'd1; tl_dtlb_miss = 1'b1; tl_flag_reg = 1'b1;
        tl_pc = 32'h100; tl_data = 32'h8004;
        #1;
        total++; if (redir_en !== 1'b1 || redir_pc !== 32'h2000) begin bad++; $display("FAIL exc_redir: got en=%b pc=%h expected 1 00002000", redir_en, redir_pc); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL exc_wen: got %b expected 0", rf_wen); end
        step();
        total++; if (dut.rm0[1] !== 32'h100 || dut.rm1[1] !== 32'h8004 || dut.rm2[1] !== 32'd2) begin bad++; $display("FAIL exc_rm: got rm0=%h rm1=%h rm2=%h expected 100 8004 2", dut.rm0[1], dut.rm1[1], dut.rm2[1]); end
        // iret returns to the saved pc and drops to user mode.
        set_idle();
        tl_isvalid = 1'b1; tl_thread = 2'd1; tl_flag_iret = 1'b1; tl_data = 32'h5555;
        #1;
        total++; if (redir_en !== 1'b1 || redir_pc !== 32'h100) begin bad++; $display("FAIL iret_redir: got en=%b pc=%h expected 1 00000100", redir_en, redir_pc); end
        step();
        total++; if (mode !== 4'b1101) begin bad++; $display("FAIL iret_mode: got %b expected 1101", mode); end
        // Both misses at once: the I-TLB miss wins and rm1 takes the pc.
        set_idle();
        tl_isvalid = 1'b1; tl_thread = 2'd2; tl_itlb_miss = 1'b1; tl_dtlb_miss = 1'b1;
        tl_pc = 32'h300; tl_data = 32'h9999;
        step();
        total++; if (dut.rm0[2] !== 32'h300 || dut.rm1[2] !== 32'h300 || dut.rm2[2] !== 32'd1) begin bad++; $display("FAIL itlb_prio: got rm0=%h rm1=%h rm2=%h expected 300 300 1", dut.rm0[2], dut.rm1[2], dut.rm2[2]); end
    endtask

    task automatic test_tlb_write();
        set_idle();
        tl_isvalid = 1'b1; tl_thread = 2'd0; tl_flag_tlbwrite = 2'd1;
        tl_data = 32'h1234_5678; tl_r2 = 32'hFFFF_FFAB;
        #1;
        total++; if (itlb_write_en !== 1'b1 || dtlb_write_en !== 1'b0) begin bad++; $display("FAIL itlbw_en: got i=%b d=%b expected 1 0", itlb_write_en, dtlb_write_en); end
        total++; if (write_vpn !== 20'h12345 || write_ppn !== 8'hAB) begin bad++; $display("FAIL tlbw_fields: got vpn=%h ppn=%h expected 12345 ab", write_vpn, write_ppn); end
        tl_flag_tlbwrite = 2'd2;
        #1;
        total++; if (itlb_write_en !== 1'b0 || dtlb_write_en !== 1'b1) begin bad++; $display("FAIL dtlbw_en: got i=%b d=%b expected 0 1", itlb_write_en, dtlb_write_en); end
        // Thread 1 is in user mode after the iret: TLB write is a no-op.
        tl_thread = 2'd1;
        #1;
        total++; if (itlb_write_en !== 1'b0 || dtlb_write_en !== 1'b0) begin bad++; $display("FAIL tlbw_user: got i=%b d=%b expected 0 0", itlb_write_en, dtlb_write_en); end
        step();
    endtask

    task automatic test_store_fill();
        st_t e;
        store_ready = 1'b0; drained = 0;
        for (int i = 0; i < 5; i++) begin
            drive_store(32'h40 + 32'(4 * i), 20'h100 + 20'(4 * i), 1'(i), e);
            #1;
            if (i < 4) begin
                total++; if (replay !== 1'b0 || redir_en !== 1'b0) begin bad++; $display("FAIL fill_accept%0d: got replay=%b redir=%b expected 0 0", i, replay, redir_en); end
                sb_q.push_back(e);
            end else begin
                total++; if (replay !== 1'b1 || redir_en !== 1'b1 || redir_pc !== 32'h50) begin bad++; $display("FAIL fill_reject: got replay=%b redir=%b pc=%h expected 1 1 00000050", replay, redir_en, redir_pc); end
            end
            if (i == 0) begin
                total++; if (store_en !== 1'b0 || sb_empty !== 1'b1) begin bad++; $display("FAIL push_latency0: got en=%b empty=%b expected 0 1", store_en, sb_empty); end
            end
            if (i == 1) begin
                total++; if (store_en !== 1'b1 || sb_empty !== 1'b0) begin bad++; $display("FAIL push_latency1: got en=%b empty=%b expected 1 0", store_en, sb_empty); end
            end
            step();
        end
        set_idle(); store_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        total++; if (drained !== 4 || sb_empty !== 1'b1) begin bad++; $display("FAIL fill_drain: got drained=%0d empty=%b expected 4 1", drained, sb_empty); end
    endtask

    task automatic test_full_drain();
        st_t e;
        store_ready = 1'b0; drained = 0;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h80 + 32'(4 * i), 20'h200 + 20'(4 * i), 1'b0, e);
            sb_q.push_back(e);
            step();
        end
        drive_store(32'h90, 20'h210, 1'b1, e);
        store_ready = 1'b1;
        #1;
        total++; if (replay !== 1'b0 || redir_en !== 1'b0) begin bad++; $display("FAIL full_pop_accept: got replay=%b redir=%b expected 0 0", replay, redir_en); end
        sb_q.push_back(e);
        step();
        total++; if (dut.sb_count !== 3'd4 || dut.sb_wrptr !== 2'd1 || dut.sb_rdptr !== 2'd1) begin bad++; $display("FAIL full_pop_state: got cnt=%0d wr=%0d rd=%0d expected 4 1 1", dut.sb_count, dut.sb_wrptr, dut.sb_rdptr); end
        set_idle();
        for (int i = 0; i < 4; i++) step();
        #1;
        total++; if (drained !== 5 || sb_empty !== 1'b1 || sb_q.size() != 0) begin bad++; $display("FAIL wrap_drain: got drained=%0d empty=%b left=%0d expected 5 1 0", drained, sb_empty, sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        st_t e;
        store_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'hC0 + 32'(4 * i), 20'h300 + 20'(4 * i), 1'b0, e);
            sb_q.push_back(e);
            step();
        end
        set_idle();
        #2;
        rst = 1'b1;
        #1;
        total++; if (store_en !== 1'b0 || sb_empty !== 1'b1) begin bad++; $display("FAIL rst_mid_sb: got en=%b empty=%b expected 0 1", store_en, sb_empty); end
        total++; if (mode !== 4'hF) begin bad++; $display("FAIL rst_mid_mode: got %h expected f", mode); end
        sb_q.delete();
        @(negedge clk); rst = 1'b0; store_ready = 1'b1;
        step();
        #1;
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rst_mid_after: got empty=%b expected 1", sb_empty); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_exception();
        test_tlb_write();
        test_store_fill();
        test_full_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- Final (write-back) stage of the multithreaded pipeline; consumes the TL→WB pipeline register.
- Retires valid instructions: register-file write, branch/jump/iret redirect, TLB writes, per-thread exception entry.
- Holds a FIFO store buffer that drains committed stores into the D-cache STORE interface, one per cycle.

Parameters:
- SB_DEPTH, 4, store buffer entries (power of two, ≥2)
- EXC_VECTOR, 32'h0000_2000, PC loaded on exception entry

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- tl_thread  in  threadid_t  issuing thread
- tl_isvalid  in  1  instruction valid
- tl_itlb_miss  in  1  I-TLB miss carried from fetch
- tl_dtlb_miss  in  1  D-TLB miss from TL
- tl_dst  in  regid_t  destination register
- tl_pc  in  vptr_t  instruction PC
- tl_r2  in  word_t  second operand (store data / ppn source)
- tl_data  in  word_t  ALU result, load data, or target/vaddr
- tl_paddr  in  pptr_t  physical address of memory op
- tl_isequal  in  1  branch compare result
- tl_mul  in  word_t  multiplier result
- tl_flag_mul / _reg / _jump / _branch / _iret / _store / _isbyte  in  1 each  decode flags
- tl_flag_tlbwrite  in  tlbwrite_t  NONE / ITLB / DTLB
- rf_wen  out  1  register write enable
- rf_thread  out  threadid_t;  rf_dst  out  regid_t;  rf_data  out  word_t
- redir_en  out  1;  redir_thread  out  threadid_t;  redir_pc  out  vptr_t  fetch redirect
- replay  out  1  store rejected (buffer full); thread must refetch tl_pc
- itlb_write_en  out  1;  dtlb_write_en  out  1;  write_vpn  out  vpn_t;  write_ppn  out  ppn_t
- store_en  out  1;  store_isbyte  out  1;  store_addr  out  pptr_t;  store_data  out  word_t
- store_ready  in  1  D-cache accepts store this cycle
- sb_empty  out  1  store buffer empty
- mode  out  n_threads  per-thread supervisor bit (rm4[0])

Behaviour:
- Retire condition: ret = tl_isvalid & ~tl_itlb_miss & ~tl_dtlb_miss. All retire outputs are combinational, same cycle.
- rf_wen = ret & tl_flag_reg. rf_data = tl_flag_mul ? tl_mul : tl_data.
- Redirect on ret, with tl_pc:
  - jump: redir_pc = tl_data
  - branch & isequal: redir_pc = tl_data
  - iret: redir_pc = rm0[thread]; mode[thread] <= 0 at the clock edge
- Exception: tl_isvalid & (itlb_miss | dtlb_miss); itlb_miss has priority.
  - Registered updates for tl_thread: rm0 <= tl_pc; rm1 <= tl_data (itlb: tl_pc); rm2 <= cause (1 = itlb, 2 = dtlb); mode <= 1.
  - redir_en = 1, redir_pc = EXC_VECTOR. rf_wen, store push and TLB write are suppressed.
- TLB write: on ret & mode[thread] & tlbwrite != NONE, assert itlb_ or dtlb_write_en with write_vpn = tl_data vpn field and write_ppn = tl_r2 low ppn bits. In user mode the instruction is a no-op.
- Store buffer: circular FIFO of {isbyte, addr, data} with wrptr, rdptr and a count of log2(SB_DEPTH)+1 bits.
  - Push on ret & tl_flag_store & accept: addr = tl_paddr, data = tl_r2.
  - accept = (count < SB_DEPTH) | pop.
  - If not accepted: replay = 1 and redir_en = 1 to tl_pc for that thread; the store does not retire.
  - Drain: store_en = (count != 0), presenting the head entry. pop = store_en & store_ready. Entry leaves on the clock edge.
  - Simultaneous push + pop: count unchanged; both pointers advance and wrap modulo SB_DEPTH.
  - Push into empty buffer: store_en goes high the next cycle (1-cycle latency).
  - sb_empty = (count == 0).
- Reset (async): count, pointers = 0; store_en = 0; sb_empty = 1; rm0/1/2 = 0; mode = all 1s.
  - Pending stores are discarded.
  - Combinational outputs depend only on inputs and reset state.

Test Plan:
- ALU retire: thread 1, flag_reg, dst = 5, data = 0x1234 → rf_wen = 1, rf_dst = 5, rf_data = 0x1234; mul variant yields tl_mul.
- Taken branch: isequal = 1, data = 0x400 → redir_en = 1, redir_pc = 0x400. With isequal = 0 → no redirect.
- DTLB miss: pc = 0x100, data = 0x8004 → redir_pc = 0x2000, rm0 = 0x100, rm1 = 0x8004, rm2 = 2, no rf write. A later iret → redir_pc = 0x100, mode = 0.
- Store buffer fill: store_ready = 0, five stores → first four accepted, fifth gets replay = 1 and redir_pc = its pc. Raising store_ready drains addr order A0..A3, one per cycle, then sb_empty = 1.
- Full + drain same cycle: count = 4, store_ready = 1, new store → accepted, count stays 4, pointer wrap verified.
- Reset mid-drain: rst pulsed with count = 3 → store_en drops immediately, sb_empty = 1, mode = all 1s.
